// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the write-back queue entry type.
package mips_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } reg_entry_t;
endpackage

// File: rtl/mips_wb_queue_if.sv
// Request side and register-file side of the write-back queue as one bundle.
// Handshake: a request transfers on a rising edge where wb_valid && wb_ready;
// wb_reg/wb_data must be stable while wb_valid is high, wb_ready never looks at wb_valid.
interface mips_wb_queue_if #(
  parameter int AW = mips_pkg::REG_AW,
  parameter int DW = mips_pkg::REG_DW
);
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          drain_en;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          signal_reg_write;

  modport master (
    output wb_valid, wb_reg, wb_data, drain_en,
    input  wb_ready, write_reg, write_data, signal_reg_write
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, drain_en,
    output wb_ready, write_reg, write_data, signal_reg_write
  );
endinterface

// File: rtl/mips_wb_match.sv
// Priority matcher: finds the newest pending queue entry for one read address.
module mips_wb_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic [AW-1:0] addr_arr_i [DEPTH],
  input  logic [DW-1:0] data_arr_i [DEPTH],
  input  logic [PW-1:0] head_i,
  input  logic [CW-1:0] count_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);
  logic [PW-1:0] idx;

  // Walk from head (oldest) towards tail so the last match seen is the newest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if ((CW'(i) < count_i) && (rd_addr_i != '0) && (addr_arr_i[idx] == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_arr_i[idx];
      end
    end
  end
endmodule

// File: rtl/mips_wb_queue.sv
// Write-back FIFO in front of the single register-file write port, with
// newest-entry bypass for the two read ports.
module mips_wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  input  logic          drain_en,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic          signal_reg_write,
  input  logic [AW-1:0] rd_addr_1,
  input  logic [AW-1:0] rd_addr_2,
  output logic          byp_hit_1,
  output logic          byp_hit_2,
  output logic [DW-1:0] byp_data_1,
  output logic [DW-1:0] byp_data_2,
  output logic [CW-1:0] count
);
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic          push, pop;

  assign wb_ready         = (count_q < CW'(DEPTH));
  assign signal_reg_write = (count_q != '0) && drain_en;
  assign write_reg        = (count_q != '0) ? addr_q[head_q] : '0;
  assign write_data       = (count_q != '0) ? data_q[head_q] : '0;
  assign count            = count_q;

  // Writes to r0 complete the handshake but are dropped here.
  assign push = wb_valid && wb_ready && (wb_reg != AW'(REG_ZERO));
  assign pop  = signal_reg_write;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push) begin
      addr_d[tail_q] = wb_reg;
      data_d[tail_q] = wb_data;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  mips_wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_1 (
    .addr_arr_i (addr_q),
    .data_arr_i (data_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .rd_addr_i  (rd_addr_1),
    .hit_o      (byp_hit_1),
    .data_o     (byp_data_1)
  );

  mips_wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_2 (
    .addr_arr_i (addr_q),
    .data_arr_i (data_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .rd_addr_i  (rd_addr_2),
    .hit_o      (byp_hit_2),
    .data_o     (byp_data_2)
  );
endmodule
